uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter (8N1, 100 MHz clock, 9600 baud) among N byte requesters. It arbitrates pending requests and latches the winner's byte. It then sequences the transmitter through a start pulse and a busy/idle handshake, and reports completion or timeout per frame. It sits between system-side byte sources (command responder, status logger, debug port) and the serial transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_if.sv | 33 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, scheduler state encoding, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // 100 MHz / 9600 baud, rounded down
  localparam int CLK_PER_BIT      = 10416;
  // Two bit periods: a healthy transmitter raises busy well inside this
  localparam int BUSY_TIMEOUT_DEF = 2 * CLK_PER_BIT;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester bus plus transmitter handshake shared by the scheduler and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: req is a level held until ack; transmitter paced by tx_busy.
interface uart_tx_scheduler_if #(
  parameter int N = 4
);
  import uart_pkg::*;

  localparam int IW = clog2_min1(N);

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [IW-1:0]  active_id;
  logic           timeout_err;

  // Scheduler side
  modport master (
    input  req, req_data, tx_busy,
    output ack, done, tx_start, tx_data, active_id, timeout_err
  );

  // Requesters plus transmitter side
  modport slave (
    output req, req_data, tx_busy,
    input  ack, done, tx_start, tx_data, active_id, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping at N.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Rotate requests so ptr+1 lands at bit 0, then take the lowest set bit
  always_comb begin
    logic [2*N-1:0] sh;
    int             pos;
    sh    = {req_i, req_i} >> (int'(ptr_i) + 1);
    pos   = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && sh[k]) begin
        vld_o = 1'b1;
        pos   = (int'(ptr_i) + 1 + k) % N;
      end
    end
    if (vld_o) begin
      gnt_o = {{(N-1){1'b0}}, 1'b1} << pos;
      idx_o = IW'(pos);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 byte transmitter among N requesters with round-robin fairness.
// Latency: ack one edge after req seen in IDLE, tx_start one cycle after ack.
// Backpressure: req held until ack; next grant waits for frame end (or timeout) plus gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_scheduler_if.master bus
);

  localparam int IW = clog2_min1(N);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = clog2_min1(GAP_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] PTR_RST  = IW'(N - 1);

  sched_state_e  state_q;
  logic [IW-1:0] ptr_q;
  logic [N-1:0]  ack_q;
  logic [N-1:0]  done_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic [IW-1:0] active_id_q;
  logic          timeout_q;
  logic [TW-1:0] to_cnt_q;
  logic [GW-1:0] gap_cnt_q;

  logic [TW-1:0] to_cnt_d;
  logic [GW-1:0] gap_cnt_d;
  logic [N-1:0]  done_d;

  logic [N-1:0]  win_gnt;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic [7:0]    win_dat;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  assign win_dat = bus.req_data[8*win_idx +: 8];

  // Timeout counter saturates so an oversized BUSY_TIMEOUT can never wrap back to zero
  assign to_cnt_d  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
  assign gap_cnt_d = gap_cnt_q + 1'b1;
  assign done_d    = {{(N-1){1'b0}}, 1'b1} << active_id_q;

  // Scheduler FSM; every output is a register so pulses are glitch-free one-cycle strobes.
  // GAP always occupies at least one cycle, so GAP_CYCLES of 0 and 1 behave alike.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      ack_q       <= '0;
      done_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      active_id_q <= '0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      ack_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            tx_data_q   <= win_dat;
            active_id_q <= win_idx;
            ack_q       <= win_gnt;
            ptr_q       <= win_idx;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          tx_start_q <= 1'b1;
          to_cnt_q   <= '0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            done_q    <= done_d;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (GAP_CYCLES <= 1 || gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.done        = done_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.active_id   = active_id_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural transmitter.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int GAP   = 5;
  localparam int BT    = BUSY_TIMEOUT_DEF;
  localparam int FRAME = 40;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N(N)) bus ();

  uart_tx_scheduler #(
    .N            (N),
    .BUSY_TIMEOUT (BT),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         exp_q[$];
  logic [7:0] dat[N];
  int         cur_id = 0;
  int         ack_cyc = 0;
  int         start_cyc = 0;
  int         end_cyc = -1;
  bit         in_frame = 0;
  bit         stuck = 0;
  bit         drop_on_ack = 1;
  bit         rearm = 0;
  int         busy_dly = 0;
  int         busy_len = 0;
  int         n_done = 0;
  int         n_to = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) begin
      dat[i] = 8'(base + 8'(i));
      bus.req_data[8*i +: 8] = dat[i];
    end
  endtask

  // One cycle: advance transmitter model, then score what the DUT shows
  task automatic tick();
    int pulses;
    @(negedge clk);
    cyc++;
    if (!reset_n) return;
    if (busy_dly > 0) begin
      busy_dly--;
      if (busy_dly == 0) begin
        bus.tx_busy = 1'b1;
        busy_len = FRAME;
      end
    end else if (busy_len > 0) begin
      busy_len--;
      if (busy_len == 0) bus.tx_busy = 1'b0;
    end
    pulses = $countones(bus.ack) + $countones(bus.done) + int'(bus.timeout_err);
    if (pulses != 0) chk("pulse_excl", 32'(pulses <= 1), 1);
    if (bus.ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(bus.ack), 0);
      end else begin
        cur_id = exp_q.pop_front();
        chk("ack_id", 32'(bus.ack), 32'(1 << cur_id));
        if (end_cyc >= 0) chk("gap_cycles", cyc - end_cyc - 1, GAP);
        ack_cyc  = cyc;
        in_frame = 1;
      end
      if (drop_on_ack) bus.req = bus.req & ~bus.ack;
    end
    if (bus.tx_start) begin
      chk("start_latency", cyc - ack_cyc, 1);
      chk("tx_data", 32'(bus.tx_data), 32'(dat[cur_id]));
      chk("active_id", 32'(bus.active_id), cur_id);
      start_cyc = cyc;
      if (!stuck) busy_dly = 3;
    end
    if (bus.done != '0) begin
      chk("done_id", 32'(bus.done), 32'(1 << cur_id));
      n_done++;
      end_cyc  = cyc;
      in_frame = 0;
      if (rearm) bus.req[cur_id] = 1'b1;
    end
    if (bus.timeout_err) begin
      chk("timeout_latency", cyc - start_cyc, BT);
      n_to++;
      end_cyc  = cyc;
      in_frame = 0;
    end
  endtask

  // Run until every expected grant is seen and its frame closed, then go quiet
  task automatic drain(input string tag, input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    bus.req = '0;
    rearm   = 0;
    while (in_frame && b < budget) begin
      tick();
      b++;
    end
    chk({tag, "_grants_left"}, exp_q.size(), 0);
    chk({tag, "_frame_open"}, 32'(in_frame), 0);
    repeat (GAP + 4) tick();
  endtask

  task automatic new_test();
    end_cyc = -1;
    n_done  = 0;
    n_to    = 0;
  endtask

  initial begin
    int b;
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_active_id", 32'(bus.active_id), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    reset_n = 1'b1;
    tick();

    // Single requester
    new_test();
    set_data(8'h00);
    dat[0] = 8'hA5;
    bus.req_data[7:0] = 8'hA5;
    drop_on_ack = 1;
    exp_q.push_back(0);
    bus.req = 4'b0001;
    drain("single", 1000);
    chk("single_done_count", n_done, 1);
    chk("hold_tx_data", 32'(bus.tx_data), 32'h0000_00A5);
    chk("hold_active_id", 32'(bus.active_id), 0);

    // All four contending, each re-raised after its own done
    new_test();
    set_data(8'h10);
    drop_on_ack = 1;
    rearm = 1;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    bus.req = 4'b1111;
    drain("contend", 3000);
    chk("contend_done_count", n_done, 5);

    // Two requesters held high continuously must alternate
    new_test();
    set_data(8'h40);
    drop_on_ack = 0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    bus.req = 4'b0011;
    drain("fair", 3000);
    chk("fair_done_count", n_done, 4);

    // Transmitter never answers: timeout, then the next grant still goes through
    new_test();
    set_data(8'h60);
    drop_on_ack = 1;
    stuck = 1;
    exp_q.push_back(0);
    bus.req = 4'b0001;
    b = 0;
    while (n_to == 0 && b < BT + 200) begin
      tick();
      b++;
    end
    chk("timeout_count", n_to, 1);
    chk("timeout_no_done", n_done, 0);
    stuck = 0;
    exp_q.push_back(1);
    bus.req = 4'b0010;
    drain("after_timeout", 1000);
    chk("after_timeout_done", n_done, 1);

    // Reset in the middle of a frame
    new_test();
    set_data(8'h80);
    drop_on_ack = 1;
    exp_q.push_back(2);
    bus.req = 4'b0100;
    b = 0;
    while (!bus.tx_busy && b < 200) begin
      tick();
      b++;
    end
    repeat (3) tick();
    reset_n     = 1'b0;
    bus.tx_busy = 1'b0;
    busy_dly    = 0;
    busy_len    = 0;
    in_frame    = 0;
    tick();
    chk("midrst_ack", 32'(bus.ack), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_tx_start", 32'(bus.tx_start), 0);
    chk("midrst_tx_data", 32'(bus.tx_data), 0);
    chk("midrst_active_id", 32'(bus.active_id), 0);
    chk("midrst_timeout", 32'(bus.timeout_err), 0);
    new_test();
    exp_q.push_back(0); exp_q.push_back(3);
    bus.req = 4'b1001;
    reset_n = 1'b1;
    drain("post_reset", 1000);
    chk("post_reset_done", n_done, 2);
    chk("post_reset_timeouts", n_to, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
